// File: rtl/arm_pkg.sv
// Shared types and encodings for the ARMv4 multicycle control unit.
// The per-state control vector lives here so the FSM and its output register agree on one table.
package arm_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH
  } state_e;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  typedef struct packed {
    logic       ir_write;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.next_pc    = 1'b1;
        c.alu_src_a  = 2'b01;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_DECODE: begin
        c.alu_src_a  = 2'b01;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_MEMADR:   c.alu_src_b = 2'b01;
      S_MEMRD:    c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_w      = 1'b1;
      end
      S_MEMWR: begin
        c.adr_src = 1'b1;
        c.mem_w   = 1'b1;
      end
      S_EXECUTER: c.alu_op = 1'b1;
      S_EXECUTEI: begin
        c.alu_src_b = 2'b01;
        c.alu_op    = 1'b1;
      end
      S_ALUWB:    c.reg_w = 1'b1;
      S_BRANCH: begin
        c.alu_src_a  = 2'b10;
        c.alu_src_b  = 2'b01;
        c.result_src = 2'b10;
        c.branch     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cond_logic.sv
// NZCV flags register, condition check and the conditional gating of the
// register-file, data-memory and PC write enables.
module cond_logic
  import arm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       next_pc,
  input  logic       branch,
  input  logic       no_write,
  input  logic       rd_is_pc,
  output logic       reg_write,
  output logic       mem_write,
  output logic       pc_write
);

  logic [3:0] flags;
  logic       n, z, c, v;
  logic       cond_ex;
  logic       cond_ex_r;
  logic       pcs;
  logic       pc_cond;

  assign {n, z, c, v} = flags;

  always_comb begin
    // NOTE: every path assigns cond_ex because of this default, so no latch is inferred.
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b0;
    endcase
  end

  // cond_ex_r freezes the verdict from EXECUTE so a flag-setting instruction
  // cannot change its own writeback outcome.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
    if (reset) begin
      flags     <= 4'b0000;
      cond_ex_r <= 1'b0;
    end else begin
      cond_ex_r <= cond_ex;
      if (flag_w[1] & cond_ex) flags[3:2] <= alu_flags[3:2];
      if (flag_w[0] & cond_ex) flags[1:0] <= alu_flags[1:0];
    end
  end

  // reg_w is only raised in the writeback states, so it doubles as the
  // selector for the latched condition on the PC path.
  assign pcs       = (rd_is_pc & reg_w) | branch;
  assign pc_cond   = reg_w ? cond_ex_r : cond_ex;
  assign pc_write  = next_pc | (pcs & pc_cond);
  assign reg_write = reg_w & cond_ex_r & ~no_write;
  assign mem_write = mem_w & cond_ex;

endmodule

// File: rtl/unidad_control.sv
// Multicycle ARMv4 control unit: Moore FSM with a registered control vector,
// ALU/instruction decode, and the conditional-execution block.
module unidad_control
  import arm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl
);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic [3:0] rd;
  logic       unused_instr_bits;

  assign cond  = Instr[31:28];
  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign cmd   = funct[4:1];
  assign rd    = Instr[15:12];
  assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

  state_e state;
  state_e next_state;
  ctrl_t  ctrl_r;
  ctrl_t  ctrl;

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_MEM:  next_state = S_MEMADR;
          OP_DP:   next_state = funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   next_state = S_BRANCH;
          default: next_state = S_FETCH;
        endcase
      end
      S_MEMADR:   next_state = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    next_state = S_MEMWB;
      S_EXECUTER: next_state = S_ALUWB;
      S_EXECUTEI: next_state = S_ALUWB;
      default:    next_state = S_FETCH;
    endcase
  end

  // The control vector is registered alongside the state so it is glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_FETCH;
      ctrl_r <= state_ctrl(S_FETCH);
    end else begin
      state  <= next_state;
      ctrl_r <= state_ctrl(next_state);
    end
  end

  // While reset is held the state register may still be mid-instruction;
  // present the FETCH vector so nothing but IR/PC can be written.
  assign ctrl = reset ? state_ctrl(S_FETCH) : ctrl_r;

  logic [1:0] flag_w;
  logic       no_write;

  always_comb begin
    ALUControl = ALU_ADD;
    flag_w     = 2'b00;
    if (ctrl.alu_op) begin
      case (cmd)
        CMD_ADD: ALUControl = ALU_ADD;
        CMD_SUB: ALUControl = ALU_SUB;
        CMD_AND: ALUControl = ALU_AND;
        CMD_ORR: ALUControl = ALU_ORR;
        CMD_CMP: ALUControl = ALU_SUB;
        default: ALUControl = ALU_ADD;
      endcase
      flag_w[1] = funct[0];
      flag_w[0] = funct[0] & ((cmd == CMD_ADD) | (cmd == CMD_SUB) | (cmd == CMD_CMP));
    end
  end

  // Taken straight from the instruction so a compare stays suppressed in ALUWB.
  assign no_write = (op == OP_DP) & (cmd == CMD_CMP);

  assign ImmSrc    = op;
  assign RegSrc    = {op == OP_MEM, op == OP_BR};
  assign IRWrite   = ctrl.ir_write;
  assign AdrSrc    = ctrl.adr_src;
  assign ResultSrc = ctrl.result_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;

  cond_logic u_cond_logic (
    .clk       (clk),
    .reset     (reset),
    .cond      (cond),
    .alu_flags (ALUFlags),
    .flag_w    (flag_w),
    .reg_w     (ctrl.reg_w),
    .mem_w     (ctrl.mem_w),
    .next_pc   (ctrl.next_pc),
    .branch    (ctrl.branch),
    .no_write  (no_write),
    .rd_is_pc  (rd == 4'hF),
    .reg_write (RegWrite),
    .mem_write (MemWrite),
    .pc_write  (PCWrite)
  );

endmodule

// File: tb/tb_unidad_control.sv
// Bench for unidad_control: an instruction-level model (step count per instruction
// class, flags updated once per instruction) checked every cycle, plus directed literals.
module tb_unidad_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl;

  always #5 clk = ~clk;

  unidad_control dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .AdrSrc     (AdrSrc),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl)
  );

  typedef enum int {
    K_FETCH, K_DECODE, K_ADDR, K_READ, K_LOADWB, K_WRITE,
    K_EXEC_REG, K_EXEC_IMM, K_WRITEBACK, K_BRANCH
  } kind_e;

  typedef struct packed {
    logic       pcw, irw, rw, mw, adr;
    logic [1:0] res, asa, asb, imm, rsrc, aluc;
  } obs_t;

  int n_checks = 0;
  int n_pass   = 0;

  int         m_step  = 0;
  logic [3:0] m_flags = 4'b0000;
  bit         m_pass  = 1'b0;
  kind_e      m_kind;

  obs_t rec [0:7];
  int   rec_n;
  obs_t cmp_act, cmp_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit cond_ok(input logic [3:0] cond, input logic [3:0] f);
    bit n = f[3];
    bit z = f[2];
    bit c = f[1];
    bit v = f[0];
    case (cond)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int inst_len(input logic [31:0] ins);
    case (ins[27:26])
      2'b00:   return 4;
      2'b01:   return ins[20] ? 5 : 4;
      2'b10:   return 3;
      default: return 2;
    endcase
  endfunction

  function automatic kind_e kind_of(input int step, input logic [31:0] ins);
    if (step == 0) return K_FETCH;
    if (step == 1) return K_DECODE;
    case (ins[27:26])
      2'b01: begin
        if (step == 2) return K_ADDR;
        if (step == 3) return ins[20] ? K_READ : K_WRITE;
        return K_LOADWB;
      end
      2'b00: begin
        if (step == 2) return ins[25] ? K_EXEC_IMM : K_EXEC_REG;
        return K_WRITEBACK;
      end
      default: return K_BRANCH;
    endcase
  endfunction

  function automatic logic [1:0] alu_ctl(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 2'b00;
      4'b0010: return 2'b01;
      4'b0000: return 2'b10;
      4'b1100: return 2'b11;
      4'b1010: return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic obs_t expected();
    obs_t       e   = '0;
    kind_e      k   = reset ? K_FETCH : kind_of(m_step, Instr);
    logic [3:0] cmd = Instr[24:21];
    e.imm  = Instr[27:26];
    e.rsrc = {Instr[27:26] == 2'b01, Instr[27:26] == 2'b10};
    case (k)
      K_FETCH:     begin e.irw = 1; e.pcw = 1; e.asa = 2'b01; e.asb = 2'b10; e.res = 2'b10; end
      K_DECODE:    begin e.asa = 2'b01; e.asb = 2'b10; e.res = 2'b10; end
      K_ADDR:      e.asb = 2'b01;
      K_READ:      e.adr = 1;
      K_LOADWB:    begin e.res = 2'b01; e.rw = m_pass; end
      K_WRITE:     begin e.adr = 1; e.mw = m_pass; end
      K_EXEC_REG:  e.aluc = alu_ctl(cmd);
      K_EXEC_IMM:  begin e.asb = 2'b01; e.aluc = alu_ctl(cmd); end
      K_WRITEBACK: e.rw = m_pass && (cmd != 4'b1010);
      K_BRANCH:    begin e.asa = 2'b10; e.asb = 2'b01; e.res = 2'b10; e.pcw = m_pass; end
      default:     e = '0;
    endcase
    if (k == K_LOADWB || k == K_WRITEBACK) e.pcw = m_pass && (Instr[15:12] == 4'hF);
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.pcw  = PCWrite;  o.irw = IRWrite;  o.rw  = RegWrite; o.mw = MemWrite;
    o.adr  = AdrSrc;   o.res = ResultSrc; o.asa = ALUSrcA;  o.asb = ALUSrcB;
    o.imm  = ImmSrc;   o.rsrc = RegSrc;  o.aluc = ALUControl;
    return o;
  endfunction

  // Model: one instruction = a fixed number of steps; its condition is judged on
  // the flags it starts with, and flags change once at its execute step.
  always @(posedge clk) begin
    if (reset) begin
      m_step  = 0;
      m_flags = 4'b0000;
    end else begin
      m_kind = kind_of(m_step, Instr);
      if (m_step == 1) m_pass = cond_ok(Instr[31:28], m_flags);
      if ((m_kind == K_EXEC_REG || m_kind == K_EXEC_IMM) && m_pass && Instr[20]) begin
        m_flags[3:2] = ALUFlags[3:2];
        if (Instr[24:21] == 4'b0100 || Instr[24:21] == 4'b0010 || Instr[24:21] == 4'b1010)
          m_flags[1:0] = ALUFlags[1:0];
      end
      m_step = (m_step + 1 >= inst_len(Instr)) ? 0 : m_step + 1;
    end
  end

  always @(negedge clk) begin
    cmp_act = sample();
    cmp_exp = expected();
    check("PCWrite",    cmp_act.pcw,  cmp_exp.pcw);
    check("IRWrite",    cmp_act.irw,  cmp_exp.irw);
    check("RegWrite",   cmp_act.rw,   cmp_exp.rw);
    check("MemWrite",   cmp_act.mw,   cmp_exp.mw);
    check("AdrSrc",     cmp_act.adr,  cmp_exp.adr);
    check("ResultSrc",  cmp_act.res,  cmp_exp.res);
    check("ALUSrcA",    cmp_act.asa,  cmp_exp.asa);
    check("ALUSrcB",    cmp_act.asb,  cmp_exp.asb);
    check("ImmSrc",     cmp_act.imm,  cmp_exp.imm);
    check("RegSrc",     cmp_act.rsrc, cmp_exp.rsrc);
    check("ALUControl", cmp_act.aluc, cmp_exp.aluc);
  end

  // Runs one instruction from its FETCH cycle; Instr is loaded as the IR would be.
  task automatic run_instr(input logic [31:0] ins, input logic [3:0] fl, input bit rand_fl,
                           input int rst_at, input bit rand_rst);
    int k = 0;
    do begin
      if (k == 1) Instr = ins;
      ALUFlags = rand_fl ? 4'($urandom) : fl;
      reset = (k == rst_at) || (rand_rst && k > 0 && $urandom_range(0, 24) == 0);
      @(negedge clk); #1;
      rec[k] = sample();
      @(posedge clk); #1;
      k++;
    end while (m_step != 0 && k < 8);
    reset = 1'b0;
    rec_n = k;
    if (m_step != 0) check("run_bound", m_step, 0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    logic [3:0]  cmds [0:4] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
    if ($urandom_range(0, 2) == 0) w[31:28] = 4'hE;
    if ($urandom_range(0, 4) != 0) w[24:21] = cmds[$urandom_range(0, 4)];
    if ($urandom_range(0, 5) == 0) w[15:12] = 4'hF;
    return w;
  endfunction

  initial begin
    reset    = 1'b1;
    Instr    = 32'h0;
    ALUFlags = 4'b0000;
    @(negedge clk); #1;
    check("rst_irwrite",  IRWrite,  1);
    check("rst_pcwrite",  PCWrite,  1);
    check("rst_regwrite", RegWrite, 0);
    check("rst_memwrite", MemWrite, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(32'hE0821003, 4'b0000, 0, -1, 0);  // ADD R1,R2,R3
    check("add_len", rec_n, 4);
    check("add_aluctl", rec[2].aluc, 2'b00);
    check("add_rw_exec", rec[2].rw, 0);
    check("add_rw_wb", rec[3].rw, 1);

    run_instr(32'hE0510001, 4'b0100, 0, -1, 0);  // SUBS sets Z
    check("subs_aluctl", rec[2].aluc, 2'b01);
    run_instr(32'h02822001, 4'b0000, 0, -1, 0);  // ADDEQ taken
    check("addeq_z_rw", rec[3].rw, 1);
    run_instr(32'hE0510001, 4'b0000, 0, -1, 0);  // SUBS clears Z
    run_instr(32'h02822001, 4'b0000, 0, -1, 0);  // ADDEQ not taken
    check("addeq_nz_rw", rec[3].rw, 0);

    run_instr(32'hE5901004, 4'b0000, 0, -1, 0);  // LDR
    check("ldr_len", rec_n, 5);
    check("ldr_alusrcb", rec[2].asb, 2'b01);
    check("ldr_immsrc", rec[2].imm, 2'b01);
    check("ldr_adrsrc", rec[3].adr, 1);
    check("ldr_resultsrc", rec[4].res, 2'b01);
    check("ldr_rw", rec[4].rw, 1);

    run_instr(32'hE5801004, 4'b0000, 0, -1, 0);  // STR
    check("str_len", rec_n, 4);
    check("str_memwrite", rec[3].mw, 1);
    check("str_regsrc", rec[3].rsrc, 2'b10);
    check("str_rw", rec[3].rw, 0);

    run_instr(32'hEA000002, 4'b0000, 0, -1, 0);  // B
    check("b_len", rec_n, 3);
    check("b_pcwrite", rec[2].pcw, 1);
    check("b_alusrca", rec[2].asa, 2'b10);
    check("b_immsrc", rec[2].imm, 2'b10);
    run_instr(32'hE0510001, 4'b0100, 0, -1, 0);
    run_instr(32'h1A000002, 4'b0000, 0, -1, 0);  // BNE with Z=1
    check("bne_pcwrite", rec[2].pcw, 0);

    run_instr(32'hEC000000, 4'b1111, 0, -1, 0);  // undefined op
    check("undef_len", rec_n, 2);

    run_instr(32'hE0510001, 4'b0100, 0, -1, 0);  // Z=1 before the abort
    run_instr(32'hE5901004, 4'b0000, 0, 3, 0);   // reset in MEMRD
    check("ldr_rst_len", rec_n, 4);
    check("ldr_rst_rw", rec[3].rw, 0);
    check("ldr_rst_irw", rec[3].irw, 1);
    check("ldr_rst_pcw", rec[3].pcw, 1);
    run_instr(32'h02822001, 4'b0000, 0, -1, 0);  // flags cleared -> EQ fails
    check("post_rst_fetch", rec[0].irw, 1);
    check("post_rst_rw", rec[3].rw, 0);

    repeat (300) run_instr(rand_instr(), 4'b0000, 1, -1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/unidad_control.md
# unidad_control

Multicycle control unit for the ARMv4 processor. Consumes the 32-bit instruction latched from `MemoriaIntrucciones` and the ALU flags, and sequences each instruction through a Moore state machine. Drives the register file write enable, data memory write enable, PC/IR write enables, datapath mux selects (`ImmSrc` into `Sign_Extend`, `RegSrc` into the register file address muxes) and `ALUControl`. Holds the NZCV flags register and the conditional-execution check.

## Interface
- No parameters. Widths are fixed by the ARMv4 datapath.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `Instr` in 32: instruction register contents. Fields used: `Cond`=[31:28], `Op`=[27:26], `Funct`=[25:20], `Rd`=[15:12].
- `ALUFlags` in 4: {N,Z,C,V} from the ALU, current cycle.
- `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite` out 1 each: write enables.
- `AdrSrc` out 1: selects the memory address, 0=PC, 1=ALUResult register.
- `ResultSrc` out 2: 00=ALUOut, 01=Data, 10=ALUResult.
- `ALUSrcA` out 2: 00=RD1, 01=PC, 10=ALUOut.
- `ALUSrcB` out 2: 00=RD2, 01=ExtImm, 10=constant 4.
- `ImmSrc`, `RegSrc`, `ALUControl` out 2 each.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE: Op=01→MEMADR; Op=00 & Funct[5]=0→EXECUTER; Op=00 & Funct[5]=1→EXECUTEI; Op=10→BRANCH; Op=11→FETCH.
  - MEMADR: Funct[0]=1→MEMRD, else MEMWR.
  - MEMRD→MEMWB→FETCH. MEMWR→FETCH. EXECUTER/EXECUTEI→ALUWB→FETCH. BRANCH→FETCH.
- State outputs (unlisted signals = 0):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, NextPC=1.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECUTER: ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: RegW=1.
  - BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode:
  - ALUOp=0: ALUControl=00, FlagW=00.
  - ALUOp=1, cmd=Funct[4:1]: ADD 0100→00; SUB 0010→01; AND 0000→10; ORR 1100→11; CMP 1010→01 with NoWrite=1; any other cmd→00.
  - FlagW[1] (NZ) = Funct[0].
  - FlagW[0] (CV) = Funct[0] & (ADD|SUB|CMP).
- ImmSrc = Op. RegSrc[0] = (Op==10). RegSrc[1] = (Op==01).
- Condition check (CondEx) against the flags register:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; Cond=1111→0.
- Flags register:
  - Flags[3:2] (NZ) load ALUFlags[3:2] when FlagW[1]&CondEx.
  - Flags[1:0] (CV) load ALUFlags[1:0] when FlagW[0]&CondEx.
  - Both load at the end of EXECUTER/EXECUTEI.
- CondExR: a flop loaded with CondEx every cycle. It is used in the writeback states so that flags written in EXECUTE do not change that instruction's own outcome.
- Gated enables:
  - RegWrite = RegW & CondExR & !NoWrite.
  - MemWrite = MemW & CondEx (MEMWR follows MEMADR, which has no flag write).
  - PCS = (Rd==15 & RegW) | Branch.
  - PCWrite = NextPC | (PCS & CondEx), using CondExR when in ALUWB/MEMWB.

## Timing
- Reset (synchronous): next state FETCH, Flags=0000, CondExR=0.
  - During reset and in the first cycle after it: IRWrite=1, PCWrite=1, all other enables 0.
- Reset asserted in any state: FETCH on the next edge; no RegWrite or MemWrite in that cycle.
- Outputs are Moore, from state plus the current Instr. No combinational path from ALUFlags to outputs other than through CondEx in the flag-write gating.
- Instruction latency, FETCH to next FETCH: B=3, STR=4, data-processing=4, LDR=5 cycles.
- Op=11 (undefined): 2 cycles with no side effects other than the PC increment.

## Structure
- Package `arm_pkg`:
  - state enum;
  - Op codes (DP=00, MEM=01, BR=10);
  - cmd codes;
  - ALUControl codes;
  - Cond codes.
- Sub-module `cond_logic`: Flags register, CondEx, CondExR, and gating of RegWrite/MemWrite/PCWrite.
- Top level: FSM plus ALU/instruction decode.

## Test plan
- Reset for 2 cycles, then Instr=0xE0821003 (ADD R1,R2,R3) → states FETCH,DECODE,EXECUTER,ALUWB,FETCH; ALUControl=00 in EXECUTER; RegWrite=1 only in ALUWB.
- 0xE0510001 (SUBS) with ALUFlags=0100 → Flags=0100 after EXECUTER; then 0x02822001 (ADDEQ) → RegWrite=1 in ALUWB; repeat with Flags=0000 → RegWrite=0.
- 0xE5901004 (LDR) → MEMADR (ALUSrcB=01), MEMRD (AdrSrc=1), MEMWB (ResultSrc=01, RegWrite=1); ImmSrc=01.
- 0xE5801004 (STR) → MEMWR with MemWrite=1, RegSrc=10, no RegWrite.
- 0xEA000002 (B) → BRANCH with PCWrite=1, ALUSrcA=10, ImmSrc=10; 0x1A000002 (BNE) with Z=1 → PCWrite=0 in BRANCH.
- Assert reset during MEMRD of an LDR → next cycle FETCH, Flags=0000, RegWrite never asserted.
